// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the MAC feeder and the MAC it drives.
package mac_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    HOLD
  } feeder_state_e;

  function automatic int acc_w(input int dw);
    return 3 * dw;
  endfunction

endpackage

// File: rtl/mac_feeder.sv
// Sequences VEC_LEN paired A/B pops into the MAC and returns one dot product per start.
// Optional build macro MAC_FEEDER_STALL_CNT_EN adds the stall_cnt output.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one-cycle mac_clr, element counter reset
// FEED  | joint A/B pop into the MAC on every cycle both streams are valid
// DRAIN | MAC finishes its last product; capture mac_cout
// HOLD  | result presented until res_ready
module mac_feeder
  import mac_pkg::*;
#(
  parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int  VEC_LEN    = 8,
  localparam int CNT_W      = $clog2(VEC_LEN + 1),
  localparam int ACC_W      = acc_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic [ACC_W-1:0]      mac_cout,
  output logic [ACC_W-1:0]      res_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  done
`ifdef MAC_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  // The bound keeps the worst-case sum inside 3*DATA_WIDTH bits.
  generate
    if (VEC_LEN < 1 || VEC_LEN > (2 ** DATA_WIDTH)) begin : g_bad_vec_len
      $error("mac_feeder: VEC_LEN must be in 1..2**DATA_WIDTH");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  feeder_state_e    state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             fire;
  logic             last;

  assign fire = (state == FEED) && a_valid && b_valid;
  assign last = (cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = FEED;
      FEED:    if (fire && last) state_nxt = DRAIN;
      DRAIN:   state_nxt = HOLD;
      HOLD:    if (res_valid && res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    mac_clr = (state == CLEAR);
    a_ready = fire;
    b_ready = fire;
    mac_en  = fire;
    mac_a   = fire ? a_data : '0;
    mac_b   = fire ? b_data : '0;
  end

  // The MAC output already includes the final product one cycle after the last pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        CLEAR: cnt <= '0;
        FEED:  if (fire) cnt <= cnt + CNT_W'(1);
        DRAIN: begin
          res_data  <= mac_cout;
          res_valid <= 1'b1;
        end
        HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MAC_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == FEED && !fire && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder paired with a behavioural two-stage MAC (mult register + accumulator).
// Honours MAC_FEEDER_STALL_CNT_EN when defined.
module tb_mac_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start8;
  logic [7:0]  a_data, b_data;
  logic        a_valid, b_valid;
  logic        res_ready, res_ready8;

  logic        busy, a_ready, b_ready, mac_en, mac_clr, res_valid, done;
  logic [7:0]  mac_a, mac_b;
  logic [23:0] mac_cout, res_data;
  logic        busy8, a_ready8, b_ready8, mac_en8, mac_clr8, res_valid8, done8;
  logic [7:0]  mac_a8, mac_b8;
  logic [23:0] mac_cout8, res_data8;
`ifdef MAC_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt8;
`endif

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always #5 clk = ~clk;

  mac_feeder #(.DATA_WIDTH(8), .VEC_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_cout(mac_cout), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .done(done)
`ifdef MAC_FEEDER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  mac_feeder #(.DATA_WIDTH(8), .VEC_LEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready8),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready8),
    .mac_en(mac_en8), .mac_clr(mac_clr8), .mac_a(mac_a8), .mac_b(mac_b8),
    .mac_cout(mac_cout8), .res_data(res_data8), .res_valid(res_valid8),
    .res_ready(res_ready8), .done(done8)
`ifdef MAC_FEEDER_STALL_CNT_EN
    , .stall_cnt(stall_cnt8)
`endif
  );

  // MAC model: registered product, accumulator; no connection to rst_n so stale sums survive reset
  logic [23:0] m_acc = '0, m_prod = '0, m8_acc = '0, m8_prod = '0;
  always @(posedge clk) begin
    if (mac_clr) begin
      m_acc <= '0; m_prod <= '0;
    end else begin
      m_acc  <= m_acc + m_prod;
      m_prod <= mac_en ? 24'(mac_a) * 24'(mac_b) : '0;
    end
    if (mac_clr8) begin
      m8_acc <= '0; m8_prod <= '0;
    end else begin
      m8_acc  <= m8_acc + m8_prod;
      m8_prod <= mac_en8 ? 24'(mac_a8) * 24'(mac_b8) : '0;
    end
  end
  assign mac_cout  = m_acc + m_prod;
  assign mac_cout8 = m8_acc + m8_prod;

  function automatic int ref_dot();
    int s = 0;
    foreach (qa[i]) s += int'(qa[i]) * int'(qb[i]);
    return s;
  endfunction

  // mode 0: both always valid; 1: a valid, b toggles 1/0 from first FEED cycle; 2: random
  task automatic drive_dot(input int n, input int mode, output logic [23:0] res, output int lat,
                           output bit proto_err, output int clr_cycles, output int stalls);
    int pops = 0;
    bit av, bv, fire_exp;
    res = '0; lat = -1; proto_err = 0; clr_cycles = 0; stalls = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (res_valid) begin lat = k + 1; res = res_data; break; end
      case (mode)
        0:       begin av = 1'b1; bv = 1'b1; end
        1:       begin av = 1'b1; bv = (k % 2 == 1); end
        default: begin av = ($urandom_range(0, 3) != 0); bv = ($urandom_range(0, 3) != 0); end
      endcase
      a_valid = av; b_valid = bv;
      a_data = (av && qa.size() > 0) ? qa[0] : 8'($urandom);
      b_data = (bv && qb.size() > 0) ? qb[0] : 8'($urandom);
      #1;
      fire_exp = (k >= 1) && (pops < n) && av && bv;
      if (k >= 1 && pops < n && !(av && bv)) stalls++;
      if (mac_clr) clr_cycles++;
      if (a_ready !== fire_exp || b_ready !== fire_exp || mac_en !== fire_exp || busy !== 1'b1) proto_err = 1;
      if (mac_clr !== (k == 0)) proto_err = 1;
      if (fire_exp && (mac_a !== qa[0] || mac_b !== qb[0])) proto_err = 1;
      if (!fire_exp && (mac_a !== 8'd0 || mac_b !== 8'd0)) proto_err = 1;
      if (fire_exp) begin void'(qa.pop_front()); void'(qb.pop_front()); pops++; end
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic release_result(input int hold, input bit poke_start, output bit hold_err,
                                output bit done_early, output logic done_pulse, output logic rv_after,
                                output logic busy_after, output logic done_after);
    logic [23:0] r0;
    r0 = res_data; hold_err = 0; done_early = 0;
    for (int i = 0; i < hold; i++) begin
      start = poke_start && (i == 1);
      @(posedge clk); @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== r0 || busy !== 1'b1) hold_err = 1;
      if (done !== 1'b0) done_early = 1;
    end
    start = 1'b0; res_ready = 1'b1;
    @(posedge clk); @(negedge clk); res_ready = 1'b0;
    done_pulse = done; rv_after = res_valid; busy_after = busy;
    @(posedge clk); @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hA5; b_data = 8'h5A;
    #1;
    n_total++;
    if ({busy, a_ready, b_ready, mac_en, mac_clr, mac_a, mac_b} !== 21'd0)
      $display("FAIL reset_comb got %h want 0", {busy, a_ready, b_ready, mac_en, mac_clr, mac_a, mac_b});
    else n_pass++;
    n_total++;
    if ({res_valid, done, res_data, res_valid8, done8, res_data8} !== 52'd0)
      $display("FAIL reset_regs got %h want 0", {res_valid, done, res_data, res_valid8, done8, res_data8});
    else n_pass++;
`ifdef MAC_FEEDER_STALL_CNT_EN
    n_total++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else n_pass++;
`endif
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [23:0] res; int lat, clr_c, st; bit perr, herr, dearly;
    logic dp, rv, bz, da;
    qa = '{8'd1, 8'd2, 8'd3, 8'd4}; qb = '{8'd5, 8'd6, 8'd7, 8'd8};
    drive_dot(4, 0, res, lat, perr, clr_c, st);
    n_total++; if (res !== 24'd70) $display("FAIL basic_res got %0d want 70", res); else n_pass++;
    n_total++; if (lat != 7) $display("FAIL basic_latency got %0d want 7", lat); else n_pass++;
    n_total++; if (perr) $display("FAIL basic_protocol got violation want none"); else n_pass++;
    release_result(0, 1'b0, herr, dearly, dp, rv, bz, da);
    n_total++;
    if ({dp, rv, bz, da} !== 4'b1000)
      $display("FAIL basic_done got done/rv/busy/done_next=%b want 1000", {dp, rv, bz, da});
    else n_pass++;
  endtask

  task automatic test_max_vec8();
    logic [23:0] r; int lat, pops; bit idle_err;
    r = '0; lat = -1; pops = 0; idle_err = 0;
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hFF; b_data = 8'hFF;
    @(negedge clk); start8 = 1'b1;
    @(posedge clk); @(negedge clk); start8 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (res_valid8) begin lat = k + 1; r = res_data8; break; end
      #1;
      if (a_ready8 && b_ready8) pops++;
      if (a_ready || busy) idle_err = 1;
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    n_total++; if (r !== 24'h07F008) $display("FAIL max_res got %h want 07f008", r); else n_pass++;
    n_total++; if (lat != 11) $display("FAIL max_latency got %0d want 11", lat); else n_pass++;
    n_total++; if (pops != 8) $display("FAIL max_pops got %0d want 8", pops); else n_pass++;
    n_total++; if (idle_err) $display("FAIL max_other_dut_idle got active want idle"); else n_pass++;
    res_ready8 = 1'b1;
    @(posedge clk); @(negedge clk); res_ready8 = 1'b0;
    n_total++;
    if ({done8, res_valid8, busy8} !== 3'b100)
      $display("FAIL max_done got done/rv/busy=%b want 100", {done8, res_valid8, busy8});
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [23:0] res; int lat, clr_c, st; bit perr, herr, dearly;
    logic dp, rv, bz, da;
    qa = '{8'd1, 8'd2, 8'd3, 8'd4}; qb = '{8'd5, 8'd6, 8'd7, 8'd8};
    drive_dot(4, 1, res, lat, perr, clr_c, st);
    n_total++; if (res !== 24'd70) $display("FAIL stall_res got %0d want 70", res); else n_pass++;
    n_total++; if (perr) $display("FAIL stall_joint_pop got violation want none"); else n_pass++;
    n_total++; if (lat != 7 + st) $display("FAIL stall_latency got %0d want %0d", lat, 7 + st); else n_pass++;
`ifdef MAC_FEEDER_STALL_CNT_EN
    n_total++; if (stall_cnt !== 16'(st)) $display("FAIL stall_cnt got %0d want %0d", stall_cnt, st); else n_pass++;
`endif
    release_result(0, 1'b0, herr, dearly, dp, rv, bz, da);
    n_total++; if (dp !== 1'b1) $display("FAIL stall_done got %b want 1", dp); else n_pass++;
`ifdef MAC_FEEDER_STALL_CNT_EN
    n_total++; if (stall_cnt !== 16'(st)) $display("FAIL stall_cnt_hold got %0d want %0d", stall_cnt, st); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [23:0] res; int lat, clr_c, st; bit perr, herr, dearly;
    logic dp, rv, bz, da;
    qa = '{8'd2, 8'd2, 8'd2, 8'd2}; qb = '{8'd3, 8'd3, 8'd3, 8'd3};
    drive_dot(4, 0, res, lat, perr, clr_c, st);
    n_total++; if (clr_c != 1) $display("FAIL b2b_clear got %0d cycles want 1", clr_c); else n_pass++;
    n_total++; if (res !== 24'd24) $display("FAIL b2b_res got %0d want 24", res); else n_pass++;
    release_result(0, 1'b0, herr, dearly, dp, rv, bz, da);
    n_total++; if (dp !== 1'b1) $display("FAIL b2b_done got %b want 1", dp); else n_pass++;
  endtask

  task automatic test_hold();
    logic [23:0] res; int lat, clr_c, st; bit perr, herr, dearly;
    logic dp, rv, bz, da;
    qa = '{8'd1, 8'd2, 8'd3, 8'd4}; qb = '{8'd5, 8'd6, 8'd7, 8'd8};
    drive_dot(4, 0, res, lat, perr, clr_c, st);
    release_result(5, 1'b1, herr, dearly, dp, rv, bz, da);
    n_total++; if (herr) $display("FAIL hold_stable got unstable want stable"); else n_pass++;
    n_total++; if (dearly) $display("FAIL hold_done_early got 1 want 0"); else n_pass++;
    n_total++;
    if ({dp, rv, bz, da} !== 4'b1000)
      $display("FAIL hold_release got done/rv/busy/done_next=%b want 1000", {dp, rv, bz, da});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [23:0] res; int lat, clr_c, st; bit perr, herr, dearly;
    logic dp, rv, bz, da;
    @(negedge clk); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'd1; b_data = 8'd5;
    @(negedge clk);
    @(negedge clk); a_data = 8'd2; b_data = 8'd6;
    @(negedge clk); a_data = 8'd3; b_data = 8'd7;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, a_ready, b_ready, mac_en, mac_clr, mac_a, mac_b, res_valid, done, res_data} !== 47'd0)
      $display("FAIL midreset_outputs got %h want 0",
               {busy, a_ready, b_ready, mac_en, mac_clr, mac_a, mac_b, res_valid, done, res_data});
    else n_pass++;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    qa = '{8'd1, 8'd2, 8'd3, 8'd4}; qb = '{8'd5, 8'd6, 8'd7, 8'd8};
    drive_dot(4, 0, res, lat, perr, clr_c, st);
    n_total++; if (res !== 24'd70) $display("FAIL midreset_rerun got %0d want 70", res); else n_pass++;
    release_result(0, 1'b0, herr, dearly, dp, rv, bz, da);
  endtask

  task automatic test_random();
    logic [23:0] res; int lat, clr_c, st, expv; bit perr, herr, dearly;
    logic dp, rv, bz, da;
    for (int it = 0; it < 6; it++) begin
      qa.delete(); qb.delete();
      for (int i = 0; i < 4; i++) begin
        qa.push_back(8'($urandom_range(0, 255)));
        qb.push_back(8'($urandom_range(0, 255)));
      end
      expv = ref_dot();
      drive_dot(4, 2, res, lat, perr, clr_c, st);
      n_total++; if (res !== 24'(expv)) $display("FAIL rand%0d_res got %0d want %0d", it, res, expv); else n_pass++;
      n_total++; if (perr) $display("FAIL rand%0d_protocol got violation want none", it); else n_pass++;
      n_total++; if (lat != 7 + st) $display("FAIL rand%0d_latency got %0d want %0d", it, lat, 7 + st); else n_pass++;
`ifdef MAC_FEEDER_STALL_CNT_EN
      n_total++; if (stall_cnt !== 16'(st)) $display("FAIL rand%0d_stall_cnt got %0d want %0d", it, stall_cnt, st); else n_pass++;
`endif
      release_result(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), herr, dearly, dp, rv, bz, da);
      n_total++;
      if (herr || dearly || {dp, rv, bz, da} !== 4'b1000)
        $display("FAIL rand%0d_release got err=%0d early=%0d flags=%b want 0 0 1000", it, herr, dearly, {dp, rv, bz, da});
      else n_pass++;
    end
  endtask

  initial begin
    start = 1'b0; start8 = 1'b0; res_ready = 1'b0; res_ready8 = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    test_reset();
    test_basic();
    test_max_vec8();
    test_stall();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Upstream sequencer for the MAC datapath. Pulls paired A/B operands from two valid/ready streams and drives the MAC's En/Clr/Ain/Bin for exactly VEC_LEN products.
- Captures the MAC's Cout as one dot-product result and presents it on a valid/ready output.
- Sits between the operand FIFOs and the MAC instance. One result per start.

Parameters:
DATA_WIDTH, 8, operand width; MAC result width is 3*DATA_WIDTH
VEC_LEN, 8, products per dot product; legal range 1..2**DATA_WIDTH, elaboration assertion otherwise
CNT_W, $clog2(VEC_LEN+1), element counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin one dot product; sampled only in IDLE
busy  out  1  high in every state except IDLE
a_data  in  DATA_WIDTH  A operand
a_valid  in  1  A operand available
a_ready  out  1  A pop
b_data  in  DATA_WIDTH  B operand
b_valid  in  1  B operand available
b_ready  out  1  B pop
mac_en  out  1  to MAC En
mac_clr  out  1  to MAC Clr
mac_a  out  DATA_WIDTH  to MAC Ain
mac_b  out  DATA_WIDTH  to MAC Bin
mac_cout  in  3*DATA_WIDTH  from MAC Cout
res_data  out  3*DATA_WIDTH  captured dot product
res_valid  out  1  result available
res_ready  in  1  result consumer accepts
done  out  1  one-cycle pulse on result handshake

Behaviour:
- Reset (async assert, synchronous release): state IDLE, cnt 0, res_data 0, res_valid 0, done 0. All combinational outputs evaluate to 0. The MAC has its own reset.
- FSM states and transitions:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: mac_clr=1 for exactly one cycle; cnt<=0. Next state FEED.
  - FEED: fire = a_valid & b_valid.
    - a_ready = b_ready = fire. Joint pop only; never pop one stream alone.
    - mac_en = fire. mac_a/mac_b = a_data/b_data, combinational (the MAC registers them).
    - On fire, cnt<=cnt+1. On fire with cnt==VEC_LEN-1, go to DRAIN.
  - DRAIN: one cycle, mac_en=0. The MAC now holds the last product in its mult register, so mac_cout equals the full sum. res_data<=mac_cout, res_valid<=1. Next state HOLD.
  - HOLD: res_valid=1 and res_data stable until res_ready=1. On that handshake: res_valid<=0, done pulses in the following cycle, state -> IDLE.
- Outside FEED-fire: mac_en=0, a_ready=b_ready=0, mac_a=mac_b=0.
- Outside CLEAR: mac_clr=0.
- Latency: start to first possible pop = 2 cycles. Last pop to res_valid = 2 cycles. With no stalls, start to res_valid = VEC_LEN+3 cycles.
- start outside IDLE is ignored; it is not queued.
- Stalls in FEED (either valid low) hold cnt and MAC state indefinitely. No timeout.
- VEC_LEN=1: FEED exits after one fire.
- Width: no saturation. The VEC_LEN bound guarantees the sum fits in 3*DATA_WIDTH.
- Reset mid-operation aborts the dot product. The next start re-clears the MAC via CLEAR, so stale accumulation never leaks into a result.

Optional Feature:
MAC_FEEDER_STALL_CNT_EN
- Defined: adds output stall_cnt [15:0]. It counts FEED cycles with fire=0, saturates at 16'hFFFF, clears on the IDLE->CLEAR transition, and holds its value after the result. Reset value 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mac_pkg: feeder_state_e enum {IDLE, CLEAR, FEED, DRAIN, HOLD}; DATA_WIDTH_DEF=8; function acc_w(dw)=3*dw shared with the MAC.
- No sub-module. The counter and FSM are small and belong in one module.
- The bench pairs this block with a MAC instance.

Test Plan:
- DW=8, VEC_LEN=4; A={1,2,3,4}, B={5,6,7,8}, both streams always valid, start pulse -> res_data=70, res_valid on cycle 7 after start, done one cycle after res_ready.
- VEC_LEN=8, A=B=255 for all 8 elements -> res_data=24'h07F008 (520200), no wrap.
- Same vectors as the first case, with b_valid toggled 1/0 and a_valid held 1 -> a_ready never high without b_ready; result 70; with MAC_FEEDER_STALL_CNT_EN, stall_cnt=3.
- Back-to-back: second start with A={2,2,2,2}, B={3,3,3,3} after done -> CLEAR pulse observed, res_data=24 (no residue from the prior 70).
- Hold res_ready low 5 cycles in HOLD; pulse start during HOLD -> res_valid stays high, res_data stable, start ignored, single done after release.
- Assert rst_n low after 2 of 4 elements popped -> all outputs 0 immediately, FSM IDLE; a fresh run with the first case's vectors yields 70.
